parity_check_scheduler: RTL

- Round-robin scheduler that shares a single even/odd classification datapath among NUM_REQ requesters.
- Each requester submits a DATA_W-bit number using valid/ready. The scheduler grants one requester and captures its number. It classifies the number in a dedicated check cycle, then returns a tagged result on a valid/ready response port.
- Sits between client blocks and the shared parity datapath. It also keeps global even/odd tallies.

---
 rtl/parity_check_scheduler.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/parity_check_scheduler.sv
// Round-robin scheduler sharing one even/odd classifier among NUM_REQ requesters.
// Optional even/odd tally counters are built only when PARITY_STATS_EN is defined.
module parity_check_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 4,
    parameter int CNT_W   = 8,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [ID_W-1:0]           resp_id,
    output logic [DATA_W-1:0]         resp_number,
    output logic                      resp_even,
    output logic                      busy,
    output logic [CNT_W-1:0]          even_count,
    output logic [CNT_W-1:0]          odd_count,
    output logic [1:0]                dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
    // valid never depends on ready, and resp_* payload is held while resp_valid waits.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [ID_W-1:0]     last_grant;
    logic [ID_W-1:0]     winner;
    logic                found;
    logic [DATA_W-1:0]   win_data;
    logic [DATA_W-1:0]   cap_number;
    logic [ID_W-1:0]     cap_id;
    logic                handshake;
    logic                resp_done;

    // Scan from the requester after the last winner, wrapping around.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && req_valid[(int'(last_grant) + k) % NUM_REQ]) begin
                found  = 1'b1;
                winner = ID_W'((int'(last_grant) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        win_data  = '0;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (int'(winner) == i) begin
                win_data     = req_data[i*DATA_W +: DATA_W];
                req_ready[i] = (state == IDLE) && found;
            end
        end
    end

    assign handshake = |(req_valid & req_ready);
    assign resp_done = resp_valid & resp_ready;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (handshake) next_state = CHECK;
            CHECK:   next_state = RESP;
            RESP:    if (resp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant  <= ID_W'(NUM_REQ - 1);
            cap_number  <= '0;
            cap_id      <= '0;
            resp_valid  <= 1'b0;
            resp_id     <= '0;
            resp_number <= '0;
            resp_even   <= 1'b0;
        end else begin
            if (state == IDLE && handshake) begin
                cap_number <= win_data;
                cap_id     <= winner;
                last_grant <= winner;
            end
            if (state == CHECK) begin
                resp_even   <= ~cap_number[0];
                resp_number <= cap_number;
                resp_id     <= cap_id;
                resp_valid  <= 1'b1;
            end else if (state == RESP && resp_ready) begin
                resp_valid  <= 1'b0;
            end
        end
    end

`ifdef PARITY_STATS_EN
    logic [CNT_W-1:0] even_q;
    logic [CNT_W-1:0] odd_q;

    // Tallies stick at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            even_q <= '0;
            odd_q  <= '0;
        end else if (resp_done) begin
            if (resp_even) begin
                if (even_q != {CNT_W{1'b1}}) even_q <= even_q + CNT_W'(1);
            end else begin
                if (odd_q != {CNT_W{1'b1}}) odd_q <= odd_q + CNT_W'(1);
            end
        end
    end

    assign even_count = even_q;
    assign odd_count  = odd_q;
`else
    assign even_count = '0;
    assign odd_count  = '0;
`endif

endmodule
